// File: rtl/pic_inta_sequencer.sv
// pic_inta_sequencer: 8259A-style interrupt-acknowledge sequencer.
// Selects the highest-priority request (IR0 highest) that may nest over the
// current in-service level, raises INT, runs the two-pulse INTA cycle, owns
// the In-Service Register and applies EOI commands.
// Optional feature macro: PIC_AUTO_EOI_EN enables automatic EOI (autoEOI=1
// clears the serviced ISR bit when the second INTA pulse ends).
`timescale 1ns/1ps

module pic_inta_sequencer #(
  parameter int INTA_SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT      = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] risedBits,
  input  logic       INTA_n,
  input  logic [7:0] ICW2,
  input  logic       eoiNonSpecific,
  input  logic       eoiSpecific,
  input  logic [2:0] eoiLevel,
  input  logic       autoEOI,
  input  logic       readPriorityAck,
  output logic       INT,
  output logic       readPriority,
  output logic [2:0] resetIRR,
  output logic [7:0] ISR,
  output logic [7:0] dataOut,
  output logic       dataOutEn,
  output logic       ackTimeout
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WACK  = 3'd2,
    WINT2 = 3'd3,
    DRV   = 3'd4
  } state_t;

  localparam logic [3:0] ACK_LIMIT = 4'(ACK_TIMEOUT);

  // Index of the lowest set bit (highest priority); 0 when no bit is set.
  function automatic logic [2:0] lowest_index(input logic [7:0] v);
    lowest_index = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_index = 3'(i);
    end
  endfunction

  state_t state;
  state_t next_state;

  logic [INTA_SYNC_STAGES-1:0] inta_sync;
  logic       inta_prev;
  logic       inta_level;
  logic       inta_fall;

  logic [2:0] cand_idx;
  logic [2:0] isr_low_idx;
  logic       eligible;

  logic [2:0] lvl;
  logic [2:0] lvl_next;
  logic       lvl_load;
  logic [3:0] ack_timer;
  logic       ack_ref;
  logic       ack_toggled;
  logic       inta_pend;
  logic [7:0] isr_next;

  logic       isr_set;
  logic       strobe;
  logic       timer_clr;
  logic       timer_inc;
  logic       timeout_set;
  logic       pend_set;
  logic       pend_clr;
  logic       vec_load;
  logic       vec_drop;
  logic       auto_clr;

  logic       unused_icw2_low;
  assign unused_icw2_low = ^ICW2[2:0];

  assign inta_level  = inta_sync[INTA_SYNC_STAGES-1];
  assign inta_fall   = inta_prev & ~inta_level;
  assign cand_idx    = lowest_index(risedBits);
  assign isr_low_idx = lowest_index(ISR);
  assign eligible    = (risedBits != 8'd0) && ((ISR == 8'd0) || (cand_idx < isr_low_idx));
  assign ack_toggled = readPriorityAck ^ ack_ref;
  assign INT         = (state == REQ);

  // Bring the asynchronous INTA_n into the clock domain; idle level is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      inta_sync <= '1;
      inta_prev <= 1'b1;
    end else begin
      inta_sync <= {inta_sync[INTA_SYNC_STAGES-2:0], INTA_n};
      inta_prev <= inta_level;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and per-cycle control decisions of the acknowledge sequence.
  always_comb begin
    next_state  = state;
    lvl_load    = 1'b0;
    lvl_next    = lvl;
    isr_set     = 1'b0;
    strobe      = 1'b0;
    timer_clr   = 1'b0;
    timer_inc   = 1'b0;
    timeout_set = 1'b0;
    pend_set    = 1'b0;
    pend_clr    = 1'b0;
    vec_load    = 1'b0;
    vec_drop    = 1'b0;
    auto_clr    = 1'b0;
    case (state)
      IDLE: begin
        if (eligible) next_state = REQ;
      end
      REQ: begin
        if (inta_fall) begin
          lvl_load = 1'b1;
          if (eligible) begin
            lvl_next   = cand_idx;
            isr_set    = 1'b1;
            strobe     = 1'b1;
            timer_clr  = 1'b1;
            next_state = WACK;
          end else begin
            lvl_next   = 3'd7;
            next_state = WINT2;
          end
        end
      end
      WACK: begin
        if (inta_fall) pend_set = 1'b1;
        if (ack_toggled) begin
          next_state = WINT2;
        end else if (ack_timer == ACK_LIMIT) begin
          timeout_set = 1'b1;
          next_state  = WINT2;
        end else begin
          timer_inc = 1'b1;
        end
      end
      WINT2: begin
        if (inta_fall || inta_pend) begin
          vec_load   = 1'b1;
          pend_clr   = 1'b1;
          next_state = DRV;
        end
      end
      DRV: begin
        if (inta_level) begin
          vec_drop   = 1'b1;
          next_state = IDLE;
`ifdef PIC_AUTO_EOI_EN
          auto_clr   = autoEOI;
`endif
        end
      end
      default: next_state = IDLE;
    endcase
  end

`ifndef PIC_AUTO_EOI_EN
  logic unused_auto_eoi;
  assign unused_auto_eoi = autoEOI;
`endif

  // Serviced level, ack watchdog, toggle reference and pending second INTA.
  always_ff @(posedge clk) begin
    if (reset) begin
      lvl        <= 3'd0;
      ack_timer  <= 4'd0;
      ack_ref    <= 1'b0;
      inta_pend  <= 1'b0;
      ackTimeout <= 1'b0;
    end else begin
      if (lvl_load)    lvl <= lvl_next;
      if (timer_clr)   ack_timer <= 4'd0;
      else if (timer_inc) ack_timer <= ack_timer + 4'd1;
      if (strobe)      ack_ref <= readPriorityAck;
      if (pend_clr)    inta_pend <= 1'b0;
      else if (pend_set) inta_pend <= 1'b1;
      if (timeout_set) ackTimeout <= 1'b1;
    end
  end

  // One-cycle IRR clear strobe; the index is held until the next strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      readPriority <= 1'b0;
      resetIRR     <= 3'd0;
    end else begin
      readPriority <= strobe;
      if (strobe) resetIRR <= lvl_next;
    end
  end

  // ISR update order: EOI (specific beats non-specific), then the new set.
  always_comb begin
    isr_next = ISR;
    if (eoiSpecific) begin
      isr_next[eoiLevel] = 1'b0;
    end else if (eoiNonSpecific && (ISR != 8'd0)) begin
      isr_next[isr_low_idx] = 1'b0;
    end
    if (isr_set)  isr_next[lvl_next] = 1'b1;
    if (auto_clr) isr_next[lvl] = 1'b0;
  end

  // In-service register.
  always_ff @(posedge clk) begin
    if (reset) ISR <= 8'd0;
    else       ISR <= isr_next;
  end

  // Vector byte driven from the second INTA until INTA_n returns high.
  always_ff @(posedge clk) begin
    if (reset) begin
      dataOut   <= 8'd0;
      dataOutEn <= 1'b0;
    end else if (vec_load) begin
      dataOut   <= {ICW2[7:3], lvl};
      dataOutEn <= 1'b1;
    end else if (vec_drop) begin
      dataOutEn <= 1'b0;
    end
  end

endmodule
